// File: rtl/maior_seq_pkg.sv
// maior_seq_pkg: shared definitions for the sequential max-finder.
//   - maior_state_e : FSM state encoding (idle / accumulate / done)
//   - WDef, CwDef   : default sample width and beat-counter width
package maior_seq_pkg;

   localparam int unsigned WDef  = 8;
   localparam int unsigned CwDef = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StDone = 2'd2
   } maior_state_e;

endpackage

// File: rtl/maior_seq_if.sv
// maior_seq_if: framed input stream plus result handshake of maior_seq.
//   Input side : in_valid, in_ready, in_data[W], in_last
//   Output side: out_valid, out_ready, out_max[W], out_count[CW]
//                out_index[CW] only when MAIOR_SEQ_INDEX_EN is defined
//   Modports   : master = producer/consumer environment, slave = maior_seq.
interface maior_seq_if
   import maior_seq_pkg::*;
#(
   parameter int unsigned W  = WDef,
   parameter int unsigned CW = CwDef
);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_max;
   logic [CW-1:0] out_count;
`ifdef MAIOR_SEQ_INDEX_EN
   logic [CW-1:0] out_index;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_max, out_count, out_index
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_max, out_count, out_index
   );
`else
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_max, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_max, out_count
   );
`endif

endinterface

// File: rtl/maior_seq_maior_menor.sv
// maior_menor: unsigned two-input maximum.
//   a_i   in  W  first operand (kept on a tie)
//   b_i   in  W  second operand
//   max_o out W  b_i if a_i < b_i, else a_i
// Shared by maior_4 (default W=8) and maior_seq.
module maior_menor #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] max_o
);

   // Strict compare so the earlier operand wins on equality.
   assign max_o = (a_i < b_i) ? b_i : a_i;

endmodule

// File: rtl/maior_seq.sv
// maior_seq: sequential max-finder over a framed stream.
//   Samples arrive one per cycle on bus.in_* (valid/ready, in_last marks the final
//   sample). A single maior_menor folds each sample into a running maximum. When the
//   last sample is accepted, the result is presented on bus.out_* until out_ready.
// Ports
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset; discards any partial stream
//   bus  slave modport of maior_seq_if (see interface for signal list)
// Parameters
//   W   sample / maximum width
//   CW  beat-counter width; counter saturates at 2^CW-1
// Build option
//   MAIOR_SEQ_INDEX_EN: adds the idx register and bus.out_index (0-based beat index
//   of the first occurrence of the maximum).
module maior_seq
   import maior_seq_pkg::*;
#(
   parameter int unsigned W  = WDef,
   parameter int unsigned CW = CwDef
) (
   input logic      clk,
   input logic      rst,
   maior_seq_if.slave bus
);

   localparam logic [CW-1:0] CntMax = '1;

   maior_state_e  state_q;
   logic [W-1:0]  acc_q;
   logic [CW-1:0] cnt_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [W-1:0]  cmp_max;
   logic          beat;
   logic          cnt_sat;
`ifdef MAIOR_SEQ_INDEX_EN
   logic [CW-1:0] idx_q;
   logic          new_max;
`endif

   maior_menor #(
      .W (W)
   ) u_maior_menor (
      .a_i   (acc_q),
      .b_i   (bus.in_data),
      .max_o (cmp_max)
   );

   assign beat    = bus.in_valid & in_ready_q;
   assign cnt_sat = (cnt_q == CntMax);

`ifdef MAIOR_SEQ_INDEX_EN
   // The comparator only departs from acc when acc < in_data, so a changed result
   // means the new sample is a strictly larger maximum.
   assign new_max = (cmp_max != acc_q);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef MAIOR_SEQ_INDEX_EN
         idx_q       <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (beat) begin
                  acc_q <= bus.in_data;
                  cnt_q <= CW'(1);
`ifdef MAIOR_SEQ_INDEX_EN
                  idx_q <= '0;
`endif
                  if (bus.in_last) begin
                     state_q     <= StDone;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= StAcc;
                  end
               end
            end

            StAcc: begin
               if (beat) begin
                  acc_q <= cmp_max;
                  if (!cnt_sat) begin
                     cnt_q <= cnt_q + CW'(1);
                  end
`ifdef MAIOR_SEQ_INDEX_EN
                  // cnt_q equals the 0-based index of this beat; frozen once saturated.
                  if (new_max && !cnt_sat) begin
                     idx_q <= cnt_q;
                  end
`endif
                  if (bus.in_last) begin
                     state_q     <= StDone;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end

            StDone: begin
               if (bus.out_ready) begin
                  state_q     <= StIdle;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_max   = acc_q;
   assign bus.out_count = cnt_q;
`ifdef MAIOR_SEQ_INDEX_EN
   assign bus.out_index = idx_q;
`endif

endmodule

// File: tb/tb_maior_seq.sv
// tb_maior_seq: directed bench for maior_seq. Two instances share one stimulus:
// u_dut8 (CW=8) and u_dut2 (CW=2, exercises counter saturation).
module tb_maior_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_ready;

   int n_checks;
   int n_pass;

   maior_seq_if #(.W(8), .CW(8)) bus8 ();
   maior_seq_if #(.W(8), .CW(2)) bus2 ();

   assign bus8.in_valid  = in_valid;
   assign bus8.in_data   = in_data;
   assign bus8.in_last   = in_last;
   assign bus8.out_ready = out_ready;
   assign bus2.in_valid  = in_valid;
   assign bus2.in_data   = in_data;
   assign bus2.in_last   = in_last;
   assign bus2.out_ready = out_ready;

   maior_seq #(.W(8), .CW(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   maior_seq #(.W(8), .CW(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat, presented for exactly one clock edge.
   task automatic send(input logic [7:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_valid", 32'(bus8.out_valid), 0);
      chk("rst_ready", 32'(bus8.in_ready), 1);
      chk("rst_max",   32'(bus8.out_max), 0);
      chk("rst_count", 32'(bus8.out_count), 0);
`ifdef MAIOR_SEQ_INDEX_EN
      chk("rst_index", 32'(bus8.out_index), 0);
`endif
      tick();
      rst = 1'b0;
      tick();

      // 1: 5,6,7,3
      send(8'd5, 1'b0);
      send(8'd6, 1'b0);
      send(8'd7, 1'b0);
      send(8'd3, 1'b1);
      chk("t1_valid", 32'(bus8.out_valid), 1);
      chk("t1_ready", 32'(bus8.in_ready), 0);
      chk("t1_max",   32'(bus8.out_max), 7);
      chk("t1_count", 32'(bus8.out_count), 4);
`ifdef MAIOR_SEQ_INDEX_EN
      chk("t1_index", 32'(bus8.out_index), 2);
`endif
      tick();
      chk("t1_valid_drop", 32'(bus8.out_valid), 0);
      chk("t1_ready_back", 32'(bus8.in_ready), 1);

      // 2: tie keeps the first occurrence
      send(8'd10, 1'b0);
      send(8'd6, 1'b0);
      send(8'd7, 1'b0);
      send(8'd10, 1'b1);
      chk("t2_max",   32'(bus8.out_max), 10);
      chk("t2_count", 32'(bus8.out_count), 4);
`ifdef MAIOR_SEQ_INDEX_EN
      chk("t2_index", 32'(bus8.out_index), 0);
`endif
      tick();

      // 3: single-beat stream
      send(8'd255, 1'b1);
      chk("t3_valid", 32'(bus8.out_valid), 1);
      chk("t3_max",   32'(bus8.out_max), 255);
      chk("t3_count", 32'(bus8.out_count), 1);
      tick();
      chk("t3_valid_drop", 32'(bus8.out_valid), 0);

      // 4: consumer back-pressure holds the result
      out_ready = 1'b0;
      send(8'd1, 1'b0);
      send(8'd9, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("t4_valid_hold", 32'(bus8.out_valid), 1);
         chk("t4_max_hold",   32'(bus8.out_max), 9);
         chk("t4_ready_hold", 32'(bus8.in_ready), 0);
         tick();
      end
      chk("t4_valid_still", 32'(bus8.out_valid), 1);
      out_ready = 1'b1;
      tick();
      chk("t4_valid_drop", 32'(bus8.out_valid), 0);
      chk("t4_ready_back", 32'(bus8.in_ready), 1);

      // 5: async reset mid-stream
      send(8'd4, 1'b0);
      send(8'd8, 1'b0);
      rst = 1'b1;
      #1;
      chk("t5_valid", 32'(bus8.out_valid), 0);
      chk("t5_ready", 32'(bus8.in_ready), 1);
      chk("t5_count", 32'(bus8.out_count), 0);
      #2;
      rst = 1'b0;
      send(8'd1, 1'b0);
      send(8'd2, 1'b1);
      chk("t5_max",   32'(bus8.out_max), 2);
      chk("t5_count2", 32'(bus8.out_count), 2);
      tick();

      // 6a: saturation, gap-free
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      send(8'd3, 1'b0);
      send(8'd4, 1'b0);
      send(8'd5, 1'b1);
      chk("t6_count_sat", 32'(bus2.out_count), 3);
      chk("t6_max_sat",   32'(bus2.out_max), 5);
      chk("t6_count8",    32'(bus8.out_count), 5);
`ifdef MAIOR_SEQ_INDEX_EN
      chk("t6_index_sat", 32'(bus2.out_index), 2);
      chk("t6_index8",    32'(bus8.out_index), 4);
`endif
      tick();

      // 6b: same stream with in_valid gaps
      send(8'd1, 1'b0);
      tick();
      send(8'd2, 1'b0);
      tick();
      tick();
      send(8'd3, 1'b0);
      send(8'd4, 1'b0);
      tick();
      chk("t6g_ready_mid", 32'(bus2.in_ready), 1);
      chk("t6g_valid_mid", 32'(bus2.out_valid), 0);
      send(8'd5, 1'b1);
      chk("t6g_valid",     32'(bus2.out_valid), 1);
      chk("t6g_count_sat", 32'(bus2.out_count), 3);
      chk("t6g_max_sat",   32'(bus2.out_max), 5);
      chk("t6g_count8",    32'(bus8.out_count), 5);
`ifdef MAIOR_SEQ_INDEX_EN
      chk("t6g_index_sat", 32'(bus2.out_index), 2);
`endif
      tick();
      chk("t6g_valid_drop", 32'(bus2.out_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
